// File: rtl/spm_arb_if.sv
// Bus bundle between the IF/MEM requesters, the scratch-pad arbiter and the SPM.
// slave = arbiter side, master = requester/SPM model side.
interface spm_arb_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              if_as_;
    logic [ADDR_W-1:0] if_addr;
    logic              if_busy;
    logic              if_rd_vld;
    logic [DATA_W-1:0] if_rd_data;

    logic              mem_as_;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_busy;
    logic              mem_rd_vld;
    logic [DATA_W-1:0] mem_rd_data;

    logic              spm_as_;
    logic              spm_rw;
    logic [ADDR_W-1:0] spm_addr;
    logic [DATA_W-1:0] spm_wr_data;
    logic [DATA_W-1:0] spm_rd_data;

    modport slave (
        input  if_as_, if_addr, mem_as_, mem_rw, mem_addr, mem_wr_data, spm_rd_data,
        output if_busy, if_rd_vld, if_rd_data, mem_busy, mem_rd_vld, mem_rd_data,
        output spm_as_, spm_rw, spm_addr, spm_wr_data
    );

    modport master (
        output if_as_, if_addr, mem_as_, mem_rw, mem_addr, mem_wr_data, spm_rd_data,
        input  if_busy, if_rd_vld, if_rd_data, mem_busy, mem_rd_vld, mem_rd_data,
        input  spm_as_, spm_rw, spm_addr, spm_wr_data
    );
endinterface

// File: rtl/spm_arb.sv
// Two-port (IF read-only, MEM read/write) scratch-pad arbiter with combinational grant.
// Define SPM_ARB_RR_EN for round-robin conflicts; otherwise MEM priority with IF starvation override.
module spm_arb #(
    parameter int ADDR_W   = 30,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic      clk,
    input  logic      reset,
    spm_arb_if.slave  bus
);
    typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_e;

    owner_e owner_q, owner_d;
    logic   pending_q, pending_d;
    logic   if_req, mem_req, conflict, if_wins, grant_if, grant_mem;

`ifdef SPM_ARB_RR_EN
    owner_e rr_last_q, rr_last_d;
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0] wait_cnt_q, wait_cnt_d;
`endif

    // Requests are masked while reset is low so the SPM stays idle during reset.
    always_comb begin
        if_req   = reset & ~bus.if_as_;
        mem_req  = reset & ~bus.mem_as_;
        conflict = if_req & mem_req;
`ifdef SPM_ARB_RR_EN
        if_wins  = (rr_last_q == OWN_MEM);
`else
        if_wins  = (wait_cnt_q == MAX_WAIT_C);
`endif
        grant_if  = if_req & (~mem_req | if_wins);
        grant_mem = mem_req & ~grant_if;
    end

    always_comb begin
        pending_d = grant_if | (grant_mem & bus.mem_rw);
        owner_d   = owner_q;
        if (grant_mem) begin
            owner_d = OWN_MEM;
        end else if (grant_if) begin
            owner_d = OWN_IF;
        end
`ifdef SPM_ARB_RR_EN
        rr_last_d = rr_last_q;
        if (conflict) begin
            rr_last_d = grant_if ? OWN_IF : OWN_MEM;
        end
`else
        wait_cnt_d = wait_cnt_q;
        if (!if_req || grant_if) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= OWN_IF;
            pending_q  <= 1'b0;
`ifdef SPM_ARB_RR_EN
            rr_last_q  <= OWN_IF;
`else
            wait_cnt_q <= 4'd0;
`endif
        end else begin
            owner_q    <= owner_d;
            pending_q  <= pending_d;
`ifdef SPM_ARB_RR_EN
            rr_last_q  <= rr_last_d;
`else
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    always_comb begin
        bus.if_busy     = if_req & ~grant_if;
        bus.mem_busy    = mem_req & ~grant_mem;

        bus.spm_as_     = ~(grant_if | grant_mem);
        bus.spm_rw      = grant_mem ? bus.mem_rw : 1'b1;
        bus.spm_addr    = '0;
        bus.spm_wr_data = '0;
        if (grant_if) begin
            bus.spm_addr = bus.if_addr;
        end else if (grant_mem) begin
            bus.spm_addr = bus.mem_addr;
            if (!bus.mem_rw) begin
                bus.spm_wr_data = bus.mem_wr_data;
            end
        end

        // Return data is steered to whoever owned the read issued last cycle.
        bus.if_rd_vld   = pending_q & (owner_q == OWN_IF);
        bus.mem_rd_vld  = pending_q & (owner_q == OWN_MEM);
        bus.if_rd_data  = bus.if_rd_vld  ? bus.spm_rd_data : '0;
        bus.mem_rd_data = bus.mem_rd_vld ? bus.spm_rd_data : '0;
    end
endmodule

// File: tb/tb_spm_arb.sv
// Directed, table-driven bench for spm_arb (builds with or without SPM_ARB_RR_EN).
module tb_spm_arb;
    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    typedef struct {
        logic              if_as_;
        logic [ADDR_W-1:0] if_addr;
        logic              mem_as_;
        logic              mem_rw;
        logic [ADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_wd;
        logic [DATA_W-1:0] spm_rd;
        logic              e_as_;
        logic              e_rw;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd;
        logic              e_if_busy;
        logic              e_mem_busy;
        logic              e_if_vld;
        logic [DATA_W-1:0] e_if_data;
        logic              e_mem_vld;
        logic [DATA_W-1:0] e_mem_data;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    spm_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    spm_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic if_as_, input logic [ADDR_W-1:0] if_addr,
                         input logic mem_as_, input logic mem_rw,
                         input logic [ADDR_W-1:0] mem_addr, input logic [DATA_W-1:0] mem_wd,
                         input logic [DATA_W-1:0] spm_rd);
        bus.if_as_      = if_as_;
        bus.if_addr     = if_addr;
        bus.mem_as_     = mem_as_;
        bus.mem_rw      = mem_rw;
        bus.mem_addr    = mem_addr;
        bus.mem_wr_data = mem_wd;
        bus.spm_rd_data = spm_rd;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1, 0, 1, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    vec_t vecs[13];
    logic exp_if;
    logic prev_if;

    initial begin
        checks = 0;
        errors = 0;

        // Reset state, with both requesters asserting to prove the masking.
        reset = 1'b0;
        drive(0, 'h10, 0, 0, 'h20, 'h1234, 'hFFFF0000);
        #2;
        chk("rst.spm_as_",   32'(bus.spm_as_),   1);
        chk("rst.spm_rw",    32'(bus.spm_rw),    1);
        chk("rst.if_busy",   32'(bus.if_busy),   0);
        chk("rst.mem_busy",  32'(bus.mem_busy),  0);
        @(posedge clk); #1;
        chk("rst.if_rd_vld", 32'(bus.if_rd_vld), 0);
        chk("rst.mem_rd_vld",32'(bus.mem_rd_vld),0);
        do_reset();

        //            if_as_ if_addr mem_as_ rw mem_addr mem_wd  spm_rd   | as_ rw addr  wd     ib mb iv id     mv md
        vecs[0]  = '{1, 'h00, 1, 1, 'h00, 'h77, 'h0,        1, 1, 'h00, 'h0,    0, 0, 0, 'h0,        0, 'h0};
        vecs[1]  = '{0, 'h10, 1, 1, 'h00, 'h77, 'h0,        0, 1, 'h10, 'h0,    0, 0, 0, 'h0,        0, 'h0};
        vecs[2]  = '{1, 'h00, 1, 1, 'h00, 'h00, 'hDEADBEEF, 1, 1, 'h00, 'h0,    0, 0, 1, 'hDEADBEEF, 0, 'h0};
        vecs[3]  = '{0, 'h30, 0, 0, 'h20, 'h55AA, 'h12345678, 0, 0, 'h20, 'h55AA, 1, 0, 0, 'h0,      0, 'h0};
        vecs[4]  = '{0, 'h30, 1, 1, 'h00, 'h00, 'h12345678, 0, 1, 'h30, 'h0,    0, 0, 0, 'h0,        0, 'h0};
        vecs[5]  = '{1, 'h00, 1, 1, 'h00, 'h00, 'hCAFEF00D, 1, 1, 'h00, 'h0,    0, 0, 1, 'hCAFEF00D, 0, 'h0};
        vecs[6]  = '{1, 'h00, 0, 1, 'h40, 'h99, 'h0,        0, 1, 'h40, 'h0,    0, 0, 0, 'h0,        0, 'h0};
        vecs[7]  = '{0, 'h44, 1, 1, 'h00, 'h00, 'h11111111, 0, 1, 'h44, 'h0,    0, 0, 0, 'h0,        1, 'h11111111};
        vecs[8]  = '{1, 'h00, 0, 1, 'h48, 'h00, 'h22222222, 0, 1, 'h48, 'h0,    0, 0, 1, 'h22222222, 0, 'h0};
        vecs[9]  = '{1, 'h00, 1, 1, 'h00, 'h00, 'h33333333, 1, 1, 'h00, 'h0,    0, 0, 0, 'h0,        1, 'h33333333};
        vecs[10] = '{1, 'h00, 1, 1, 'h00, 'h00, 'h44444444, 1, 1, 'h00, 'h0,    0, 0, 0, 'h0,        0, 'h0};
        vecs[11] = '{1, 'h00, 0, 0, 'h50, 'hA5A5A5A5, 'h0,  0, 0, 'h50, 'hA5A5A5A5, 0, 0, 0, 'h0,    0, 'h0};
        vecs[12] = '{1, 'h00, 1, 1, 'h00, 'h00, 'h55555555, 1, 1, 'h00, 'h0,    0, 0, 0, 'h0,        0, 'h0};

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].if_as_, vecs[i].if_addr, vecs[i].mem_as_, vecs[i].mem_rw,
                  vecs[i].mem_addr, vecs[i].mem_wd, vecs[i].spm_rd);
            @(negedge clk);
            $display("vec %0d: spm_as_=%0b rw=%0b addr=0x%0h if_busy=%0b mem_busy=%0b if_vld=%0b mem_vld=%0b",
                     i, bus.spm_as_, bus.spm_rw, bus.spm_addr, bus.if_busy, bus.mem_busy,
                     bus.if_rd_vld, bus.mem_rd_vld);
            chk($sformatf("v%0d.spm_as_", i),     32'(bus.spm_as_),     32'(vecs[i].e_as_));
            chk($sformatf("v%0d.spm_rw", i),      32'(bus.spm_rw),      32'(vecs[i].e_rw));
            chk($sformatf("v%0d.spm_addr", i),    32'(bus.spm_addr),    32'(vecs[i].e_addr));
            chk($sformatf("v%0d.spm_wr_data", i), bus.spm_wr_data,      vecs[i].e_wd);
            chk($sformatf("v%0d.if_busy", i),     32'(bus.if_busy),     32'(vecs[i].e_if_busy));
            chk($sformatf("v%0d.mem_busy", i),    32'(bus.mem_busy),    32'(vecs[i].e_mem_busy));
            chk($sformatf("v%0d.if_rd_vld", i),   32'(bus.if_rd_vld),   32'(vecs[i].e_if_vld));
            chk($sformatf("v%0d.if_rd_data", i),  bus.if_rd_data,       vecs[i].e_if_data);
            chk($sformatf("v%0d.mem_rd_vld", i),  32'(bus.mem_rd_vld),  32'(vecs[i].e_mem_vld));
            chk($sformatf("v%0d.mem_rd_data", i), bus.mem_rd_data,      vecs[i].e_mem_data);
        end

        // Continuous conflict: IF reads 0x100, MEM writes 0x200.
        do_reset();
        prev_if = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            drive(0, 'h100, 0, 0, 'h200, 'h77, 32'hB0000000 + 32'(c));
            @(negedge clk);
`ifdef SPM_ARB_RR_EN
            exp_if = (c % 2) == 1;
`else
            exp_if = (c == 4) || (c == 9);
`endif
            $display("conflict cycle %0d: spm_addr=0x%0h if_busy=%0b mem_busy=%0b if_vld=%0b",
                     c, bus.spm_addr, bus.if_busy, bus.mem_busy, bus.if_rd_vld);
            chk($sformatf("cf%0d.spm_addr", c),  32'(bus.spm_addr),  exp_if ? 32'h100 : 32'h200);
            chk($sformatf("cf%0d.if_busy", c),   32'(bus.if_busy),   32'(!exp_if));
            chk($sformatf("cf%0d.mem_busy", c),  32'(bus.mem_busy),  32'(exp_if));
            chk($sformatf("cf%0d.if_rd_vld", c), 32'(bus.if_rd_vld), 32'(prev_if));
            prev_if = exp_if;
        end

        // MEM was denied in the last conflict cycle and now flushes its request.
        @(posedge clk); #1;
        drive(0, 'h100, 1, 0, 'h200, 'h77, 'hF1F1F1F1);
        @(negedge clk);
        $display("flush: spm_as_=%0b spm_addr=0x%0h mem_busy=%0b if_vld=%0b",
                 bus.spm_as_, bus.spm_addr, bus.mem_busy, bus.if_rd_vld);
        chk("flush.spm_as_",    32'(bus.spm_as_),    0);
        chk("flush.spm_addr",   32'(bus.spm_addr),   32'h100);
        chk("flush.mem_busy",   32'(bus.mem_busy),   0);
        chk("flush.if_busy",    32'(bus.if_busy),    0);
        chk("flush.if_rd_vld",  32'(bus.if_rd_vld),  1);
        chk("flush.if_rd_data", bus.if_rd_data,      32'hF1F1F1F1);

        // MEM read granted, then reset asserted half a cycle later.
        do_reset();
        @(posedge clk); #1;
        drive(1, 0, 0, 1, 'h60, 0, 0);
        @(negedge clk);
        chk("mrst.grant_as_",   32'(bus.spm_as_),    0);
        chk("mrst.grant_addr",  32'(bus.spm_addr),   32'h60);
        reset = 1'b0;
        bus.spm_rd_data = 32'hBAD0BAD0;
        #1;
        chk("mrst.in_rst_as_",  32'(bus.spm_as_),    1);
        chk("mrst.in_rst_busy", 32'(bus.mem_busy),   0);
        @(posedge clk); #1;
        $display("mid-read reset: spm_as_=%0b mem_vld=%0b", bus.spm_as_, bus.mem_rd_vld);
        chk("mrst.rd_vld",      32'(bus.mem_rd_vld), 0);
        chk("mrst.rd_data",     bus.mem_rd_data,     0);
        chk("mrst.hold_as_",    32'(bus.spm_as_),    1);
        @(negedge clk);
        bus.mem_as_ = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst.post_vld",    32'(bus.mem_rd_vld), 0);
        chk("mrst.post_if_vld", 32'(bus.if_rd_vld),  0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spm_arb.md
SPM_ARB -- requirements
Module: spm_arb

Interface
REQ-001 Parameter ADDR_W, 30, SPM word-address width.
REQ-002 Parameter DATA_W, 32, SPM data width.
REQ-003 Parameter MAX_WAIT, 4, consecutive IF denials before IF is forced to win; range 1..15.
REQ-004 clk  in  1  clock; single clock domain; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 if_as_  in  1  IF request, active-low; IF requests are read-only.
REQ-007 if_addr  in  ADDR_W  IF word address.
REQ-008 if_busy  out  1  IF stall: request present and not granted this cycle.
REQ-009 if_rd_vld  out  1  IF read data valid.
REQ-010 if_rd_data  out  DATA_W  IF read data.
REQ-011 mem_as_  in  1  MEM request, active-low.
REQ-012 mem_rw  in  1  MEM direction: 1 = read, 0 = write.
REQ-013 mem_addr  in  ADDR_W  MEM word address.
REQ-014 mem_wr_data  in  DATA_W  MEM write data.
REQ-015 mem_busy  out  1  MEM stall: request present and not granted this cycle.
REQ-016 mem_rd_vld  out  1  MEM read data valid.
REQ-017 mem_rd_data  out  DATA_W  MEM read data.
REQ-018 spm_as_  out  1  SPM strobe, active-low.
REQ-019 spm_rw  out  1  SPM direction: 1 = read, 0 = write.
REQ-020 spm_addr  out  ADDR_W  SPM address.
REQ-021 spm_wr_data  out  DATA_W  SPM write data.
REQ-022 spm_rd_data  in  DATA_W  SPM read data, valid one cycle after a read strobe.

Function
REQ-023 Grant decision: combinational; at most one SPM access per cycle.
- Granted request is driven onto spm_as_/spm_rw/spm_addr/spm_wr_data in the same cycle.
REQ-024 Single requester: always granted; its busy output is 0.
REQ-025 No requester: spm_as_=1, spm_rw=1; spm_addr and spm_wr_data are 0.
REQ-026 Conflict, default mode: MEM wins unless wait_cnt==MAX_WAIT, in which case IF wins.
REQ-027 Loser of a conflict: busy=1 that cycle; it must hold its request, and may drop it at any time (flush).
REQ-028 wait_cnt (4 bits):
- increments on each cycle IF is denied;
- clears on an IF grant or when if_as_=1;
- saturates at MAX_WAIT.
REQ-029 SPM write (MEM, mem_rw=0): completes in the grant cycle; no rd_vld is generated.
REQ-030 Read: in the cycle after a granted read, the owner's rd_vld=1 and its rd_data=spm_rd_data.
- Owner is held in a registered owner flag plus one pending bit.
REQ-031 Non-owner rd_vld is 0; rd_data outputs are 0 whenever their rd_vld is 0.
REQ-032 Back-to-back reads are allowed: a grant in cycle N+1 may overlap the return for the read granted in cycle N.
REQ-033 Busy is purely combinational from the requests and the arbiter state; it is never asserted without a request.

Reset
REQ-034 While reset=0:
- spm_as_=1, spm_rw=1;
- if_busy, mem_busy, if_rd_vld, mem_rd_vld = 0;
- wait_cnt=0, pending=0, owner=IF, rr_last=IF.
REQ-035 Reset mid-read: the read return is discarded; no rd_vld is generated after reset release.
REQ-036 The first grant decision occurs on the first rising edge after reset deasserts.

Configuration
REQ-037 Macro SPM_ARB_RR_EN, when defined: conflicts resolve round-robin.
- Winner is the port opposite rr_last; rr_last updates on every conflict grant.
- wait_cnt and MAX_WAIT logic are omitted.
REQ-038 SPM_ARB_RR_EN undefined: fixed MEM priority with the starvation override of REQ-026/028; rr_last is absent.

Verification
REQ-039 IF-only read, addr 0x10, SPM returns 0xDEADBEEF: spm_as_=0 in cycle 0; if_rd_vld=1 with 0xDEADBEEF in cycle 1; if_busy=0 throughout.
REQ-040 MEM write 0x55AA to 0x20 alongside an IF read of 0x30 (default mode): spm_rw=0, spm_addr=0x20, if_busy=1 in cycle 0; IF granted in cycle 1 and data returned in cycle 2.
REQ-041 Continuous conflict for 10 cycles, MAX_WAIT=4, default mode: IF granted in cycles 4 and 9; wait_cnt returns to 0 after each IF grant.
REQ-042 Same stimulus with SPM_ARB_RR_EN defined: grants alternate MEM, IF, MEM, IF; each busy is asserted every other cycle.
REQ-043 MEM read granted at cycle 0, reset asserted at cycle 0.5: mem_rd_vld stays 0 and spm_as_=1 until reset release.
REQ-044 MEM denied at cycle 0 drops mem_as_ at cycle 1 (flush): no access to the MEM address occurs and mem_busy=0 at cycle 1.
